// File: rtl/adc_serial_cfg.sv
// ---------------------------------------------------------------------------
// adc_serial_cfg
//   Serial-port programmer for NUM_DEV CIS front-end ADCs. The ADCs share
//   sclk/sdata, and each one has its own active-low load strobe. An accepted
//   request snapshots the register table. The block then writes either every
//   (device, register) entry or one selected entry. Each entry goes out as an
//   MSB-first frame {write=0, addr, PAD_W zeros, data}. The ADC samples sdata
//   on the rising edge of sclk.
//
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   start      in   1-cycle request, accepted only while busy=0
//   single     in   sampled with start: 1 = one register, 0 = whole table
//   sel_dev    in   device index for a single write
//   sel_reg    in   register index for a single write
//   reg_table  in   entry (d,r) at [(d*NUM_REGS+r)*DATA_W +: DATA_W]
//   busy       out  high from the cycle after accept until the done cycle
//   done       out  1-cycle pulse at the end of a request
//   err        out  1-cycle pulse with done for an out-of-range selection
//   sclk       out  serial clock, idle low
//   sdata      out  serial data, idle low
//   sload_n    out  per-device load strobe, active low, idle all ones
// ---------------------------------------------------------------------------
module adc_serial_cfg #(
    parameter int NUM_DEV  = 2,
    parameter int NUM_REGS = 6,
    parameter int ADDR_W   = 3,
    parameter int PAD_W    = 3,
    parameter int DATA_W   = 9,
    parameter int DIV      = 5,
    localparam int DEV_W   = (NUM_DEV  > 1) ? $clog2(NUM_DEV)  : 1,
    localparam int REG_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               start,
    input  logic                               single,
    input  logic [DEV_W-1:0]                   sel_dev,
    input  logic [REG_W-1:0]                   sel_reg,
    input  logic [NUM_DEV*NUM_REGS*DATA_W-1:0] reg_table,
    output logic                               busy,
    output logic                               done,
    output logic                               err,
    output logic                               sclk,
    output logic                               sdata,
    output logic [NUM_DEV-1:0]                 sload_n
);

    localparam int FRAME_W = 1 + ADDR_W + PAD_W + DATA_W;
    localparam int HALF_N  = 2 * FRAME_W;
    localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HALF_W  = $clog2(HALF_N);
    localparam int BIT_W   = $clog2(FRAME_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP,
        S_FIN,
        S_ERR
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt,   w_cnt_nxt;
    logic [HALF_W-1:0]   r_half,  w_half_nxt;
    logic [DEV_W-1:0]    r_dev,   w_dev_nxt;
    logic [REG_W-1:0]    r_reg,   w_reg_nxt;
    logic                r_single, w_single_nxt;
    logic [DATA_W-1:0]   r_tab [NUM_DEV][NUM_REGS];

    logic                r_busy, r_done, r_err, r_sclk, r_sdata;
    logic [NUM_DEV-1:0]  r_sload_n;
    logic                w_busy_nxt, w_done_nxt, w_err_nxt, w_sclk_nxt, w_sdata_nxt;
    logic [NUM_DEV-1:0]  w_sload_n_nxt;

    logic                w_accept, w_sel_bad, w_cnt_end, w_last;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_entry;
    logic [FRAME_W-1:0]  w_frame;
    logic [BIT_W-1:0]    w_bit;

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_sel_bad = (int'(sel_dev) >= NUM_DEV) || (int'(sel_reg) >= NUM_REGS);
    assign w_cnt_end = (r_cnt == CNT_W'(DIV - 1));
    assign w_last    = r_single ||
                       ((r_dev == DEV_W'(NUM_DEV - 1)) && (r_reg == REG_W'(NUM_REGS - 1)));

    // Frame of the entry currently being sent; register i is written to address i.
    assign w_addr  = ADDR_W'(r_reg);
    assign w_entry = r_tab[r_dev][r_reg];
    assign w_frame = (FRAME_W'(w_addr) << (PAD_W + DATA_W)) | FRAME_W'(w_entry);

    // Each bit spans two half periods (low then high), MSB first.
    assign w_bit = BIT_W'(FRAME_W - 1) - BIT_W'(w_half_nxt >> 1);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = w_cnt_end ? '0 : r_cnt + 1'b1;
        w_half_nxt   = r_half;
        w_dev_nxt    = r_dev;
        w_reg_nxt    = r_reg;
        w_single_nxt = r_single;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt  = '0;
                w_half_nxt = '0;
                if (w_accept) begin
                    w_single_nxt = single;
                    w_dev_nxt    = single ? sel_dev : '0;
                    w_reg_nxt    = single ? sel_reg : '0;
                    w_state_nxt  = (single && w_sel_bad) ? S_ERR : S_SETUP;
                end
            end
            S_SETUP: begin
                if (w_cnt_end) begin
                    w_state_nxt = S_SHIFT;
                    w_half_nxt  = '0;
                end
            end
            S_SHIFT: begin
                if (w_cnt_end) begin
                    if (r_half == HALF_W'(HALF_N - 1)) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_half_nxt = r_half + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (w_cnt_end) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (w_cnt_end) begin
                    if (w_last) begin
                        w_state_nxt = S_FIN;
                    end else begin
                        w_state_nxt = S_SETUP;
                        if (r_reg == REG_W'(NUM_REGS - 1)) begin
                            w_reg_nxt = '0;
                            w_dev_nxt = r_dev + 1'b1;
                        end else begin
                            w_reg_nxt = r_reg + 1'b1;
                        end
                    end
                end
            end
            S_FIN, S_ERR: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so each line
    // shows the value of the state it belongs to, with no input-to-output path.
    always_comb begin
        w_busy_nxt    = (w_state_nxt != S_IDLE);
        w_done_nxt    = (w_state_nxt == S_FIN) || (w_state_nxt == S_ERR);
        w_err_nxt     = (w_state_nxt == S_ERR);
        w_sclk_nxt    = (w_state_nxt == S_SHIFT) && w_half_nxt[0];
        w_sdata_nxt   = 1'b0;
        w_sload_n_nxt = '1;
        if (w_state_nxt == S_SHIFT) begin
            w_sdata_nxt = w_frame[w_bit];
        end
        // In SETUP, sdata shows the frame MSB. That bit is the write flag, which is always 0.
        if ((w_state_nxt == S_SETUP) || (w_state_nxt == S_SHIFT) || (w_state_nxt == S_HOLD)) begin
            w_sload_n_nxt[w_dev_nxt] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_half    <= '0;
            r_dev     <= '0;
            r_reg     <= '0;
            r_single  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_sclk    <= 1'b0;
            r_sdata   <= 1'b0;
            r_sload_n <= '1;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_half    <= w_half_nxt;
            r_dev     <= w_dev_nxt;
            r_reg     <= w_reg_nxt;
            r_single  <= w_single_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_sclk    <= w_sclk_nxt;
            r_sdata   <= w_sdata_nxt;
            r_sload_n <= w_sload_n_nxt;
        end
    end

    // The table snapshot is pure data. It is only ever read after an accept has loaded it.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int d = 0; d < NUM_DEV; d++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    r_tab[d][r] <= reg_table[(d*NUM_REGS + r)*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;
    assign sclk    = r_sclk;
    assign sdata   = r_sdata;
    assign sload_n = r_sload_n;

endmodule
